// File: rtl/uart_pkg.sv
// Shared UART definitions: receive-state encodings, parity sense, key and oversampling constants.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  localparam logic [7:0] XOR_KEY_DEFAULT = 8'h45;

  // Ticks per bit period and the tick index treated as mid-bit.
  localparam int         OVERSAMPLE  = 16;
  localparam logic [3:0] MID_SAMPLE  = 4'd7;
  localparam logic [3:0] LAST_SAMPLE = 4'(OVERSAMPLE - 1);

  // Parity bit a transmitter attaches to a byte; odd_i selects odd parity.
  function automatic logic parity_bit(input logic [7:0] byte_i, input logic odd_i);
    return (^byte_i) ^ odd_i;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous level; both flops reset to 1 (idle line level).
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Shift the asynchronous input through two flops to settle metastability.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/receiver.sv
// UART receiver: 16x oversampled start/data/parity/stop capture, parity check on the
// encrypted byte, XOR decryption and a ready/clear handshake with error flags.
module receiver
  import uart_pkg::*;
#(
  parameter bit         PARITY_EN   = 1'b1,
  parameter bit         PARITY_TYPE = PARITY_EVEN,
  parameter logic [7:0] XOR_KEY     = XOR_KEY_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_tick2,
  input  logic       rx,
  input  logic       rdy_clr,
  output logic [7:0] data_out,
  output logic       ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  logic       rx_s;
  rx_state_e  state_q;
  logic [3:0] cnt_q;
  logic [2:0] bit_idx_q;
  logic [7:0] shift_q;
  logic       p_rx_q;
  logic       armed_q;
  logic [7:0] data_q;
  logic       ready_q;
  logic       parity_err_q;
  logic       frame_err_q;
  logic       overrun_q;
  logic       busy_q;

  sync_2ff u_rx_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx),
    .q_o (rx_s)
  );

  // Receive FSM plus handshake: state advances on ticks, ready/overrun clearing acts every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      bit_idx_q    <= 3'd0;
      shift_q      <= 8'h00;
      p_rx_q       <= 1'b0;
      armed_q      <= 1'b0;
      data_q       <= 8'h00;
      ready_q      <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      if (rdy_clr) begin
        ready_q   <= 1'b0;
        overrun_q <= 1'b0;
      end
      if (baud_tick2) begin
        case (state_q)
          IDLE: begin
            // A start edge only counts once the line has been seen idle-high,
            // so a held-low break cannot retrigger frames.
            if (rx_s) begin
              armed_q <= 1'b1;
            end else if (armed_q) begin
              state_q <= START;
              cnt_q   <= 4'd0;
              armed_q <= 1'b0;
              busy_q  <= 1'b1;
            end
          end
          START: begin
            if (cnt_q == MID_SAMPLE) begin
              cnt_q <= 4'd0;
              if (!rx_s) begin
                state_q   <= DATA;
                bit_idx_q <= 3'd0;
              end else begin
                // Line went back high before mid-start: treat as a glitch.
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
          DATA: begin
            if (cnt_q == LAST_SAMPLE) begin
              cnt_q            <= 4'd0;
              shift_q[bit_idx_q] <= rx_s;
              if (bit_idx_q == 3'd7) begin
                bit_idx_q <= 3'd0;
                if (PARITY_EN) begin
                  state_q <= PARITY;
                end else begin
                  state_q <= STOP;
                end
              end else begin
                bit_idx_q <= bit_idx_q + 3'd1;
              end
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
          PARITY: begin
            if (cnt_q == LAST_SAMPLE) begin
              cnt_q   <= 4'd0;
              p_rx_q  <= rx_s;
              state_q <= STOP;
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
          STOP: begin
            if (cnt_q == LAST_SAMPLE) begin
              cnt_q        <= 4'd0;
              state_q      <= IDLE;
              busy_q       <= 1'b0;
              data_q       <= shift_q ^ XOR_KEY;
              ready_q      <= 1'b1;
              frame_err_q  <= ~rx_s;
              // A clear arriving with completion acknowledges the old byte.
              overrun_q    <= (overrun_q | ready_q) & ~rdy_clr;
              if (PARITY_EN) begin
                parity_err_q <= (p_rx_q != parity_bit(shift_q, PARITY_TYPE));
              end else begin
                parity_err_q <= 1'b0;
              end
              if (!rx_s) begin
                armed_q <= 1'b0;
              end
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign data_out   = data_q;
  assign ready      = ready_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_receiver.sv
// Scoreboard bench for receiver: stimulus pushes expected frames, a monitor pops at completion.
module tb_receiver;

  logic       clk;
  logic       rst;
  logic       baud_tick2;
  logic       rx;
  logic       rdy_clr;
  logic [7:0] data_out;
  logic       ready;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       ovr;
  } exp_t;

  exp_t exp_q[$];
  int   tests;
  int   fails;
  int   frames_seen;

  receiver dut (
    .clk        (clk),
    .rst        (rst),
    .baud_tick2 (baud_tick2),
    .rx         (rx),
    .rdy_clr    (rdy_clr),
    .data_out   (data_out),
    .ready      (ready),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Baud tick every 4 clocks, changed on the falling edge.
  initial begin
    int cnt;
    cnt = 0;
    baud_tick2 = 1'b0;
    forever begin
      @(negedge clk);
      cnt = (cnt + 1) % 4;
      baud_tick2 = (cnt == 0);
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wait_tick();
    do @(posedge clk); while (!baud_tick2);
  endtask

  // Hold rx at b for n ticks; returns on the falling edge after the last tick.
  task automatic drive(input logic b, input int n);
    rx = b;
    repeat (n) wait_tick();
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] line, input logic pbit, input logic stopbit);
    drive(1'b0, 16);
    for (int i = 0; i < 8; i++) drive(line[i], 16);
    drive(pbit, 16);
    drive(stopbit, 16);
  endtask

  task automatic expect_frame(input logic [7:0] d, input logic pe, input logic fe, input logic ov);
    exp_t e;
    e.data = d; e.perr = pe; e.ferr = fe; e.ovr = ov;
    exp_q.push_back(e);
  endtask

  task automatic pulse_clear();
    rdy_clr = 1'b1;
    @(negedge clk);
    rdy_clr = 1'b0;
  endtask

  // Monitor: a frame completes when busy falls with ready high.
  initial begin
    logic busy_prev;
    exp_t e;
    busy_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (busy_prev && !busy && ready) begin
        frames_seen++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_frame: got data %h, expected no frame", data_out);
        end else begin
          e = exp_q.pop_front();
          check("frame_data", data_out, e.data);
          check("frame_parity_err", {7'd0, parity_err}, {7'd0, e.perr});
          check("frame_frame_err", {7'd0, frame_err}, {7'd0, e.ferr});
          check("frame_overrun", {7'd0, overrun}, {7'd0, e.ovr});
        end
      end
      busy_prev = busy;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    tests = 0;
    fails = 0;
    frames_seen = 0;
    rst = 1'b1;
    rx = 1'b1;
    rdy_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data_out", data_out, 8'h00);
    check("rst_ready", {7'd0, ready}, 8'h00);
    check("rst_flags", {5'd0, parity_err, frame_err, overrun}, 8'h00);
    check("rst_busy", {7'd0, busy}, 8'h00);
    rst = 1'b0;
    wait_tick();
    @(negedge clk);
    drive(1'b1, 16);

    // Plaintext A5 -> line E0, even parity 1.
    expect_frame(8'hA5, 1'b0, 1'b0, 1'b0);
    send_frame(8'hE0, 1'b1, 1'b1);
    check("a5_ready", {7'd0, ready}, 8'h01);
    pulse_clear();
    check("a5_ready_cleared", {7'd0, ready}, 8'h00);
    drive(1'b1, 16);

    // Start glitch: low for 4 ticks only.
    drive(1'b0, 4);
    drive(1'b1, 2);
    check("glitch_busy_mid", {7'd0, busy}, 8'h01);
    drive(1'b1, 20);
    check("glitch_busy_after", {7'd0, busy}, 8'h00);
    check("glitch_ready", {7'd0, ready}, 8'h00);
    check("glitch_flags", {5'd0, parity_err, frame_err, overrun}, 8'h00);

    // Same A5 frame with wrong parity bit.
    expect_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    send_frame(8'hE0, 1'b0, 1'b1);
    pulse_clear();
    drive(1'b1, 16);

    // Line 45 (parity 1) with stop bit low, then break held low.
    expect_frame(8'h00, 1'b0, 1'b1, 1'b0);
    send_frame(8'h45, 1'b1, 1'b0);
    drive(1'b0, 48);
    check("break_busy", {7'd0, busy}, 8'h00);
    drive(1'b1, 20);
    pulse_clear();
    check("ferr_ready_cleared", {7'd0, ready}, 8'h00);

    // Two frames without a clear: 11 (line 54) then 22 (line 67).
    expect_frame(8'h11, 1'b0, 1'b0, 1'b0);
    send_frame(8'h54, 1'b1, 1'b1);
    drive(1'b1, 8);
    expect_frame(8'h22, 1'b0, 1'b0, 1'b1);
    send_frame(8'h67, 1'b1, 1'b1);
    check("ovr_set", {7'd0, overrun}, 8'h01);
    pulse_clear();
    check("ovr_cleared", {7'd0, overrun}, 8'h00);
    check("ovr_ready_cleared", {7'd0, ready}, 8'h00);
    drive(1'b1, 16);

    // Reset during data bit 4 of a frame for 3C (line 79).
    drive(1'b0, 16);
    for (int i = 0; i < 4; i++) drive(1'b1, 16);
    drive(1'b1, 8);
    check("pre_rst_busy", {7'd0, busy}, 8'h01);
    rst = 1'b1;
    rx = 1'b1;
    #1;
    check("midrst_data_out", data_out, 8'h00);
    check("midrst_busy", {7'd0, busy}, 8'h00);
    check("midrst_flags", {4'd0, ready, parity_err, frame_err, overrun}, 8'h00);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_tick();
    @(negedge clk);
    drive(1'b1, 16);
    expect_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    send_frame(8'h79, 1'b1, 1'b1);
    drive(1'b1, 8);

    check("frames_seen", 8'(frames_seen), 8'd6);
    check("queue_empty", 8'(exp_q.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
